fp_div_sequencer: RTL and testbench



---
 rtl/fp_div_pkg.sv | 53 +++++
 rtl/fp_div_special.sv | 35 +++
 rtl/fp_div_sequencer.sv | 169 ++++++++++++++++
 tb/tb_fp_div_sequencer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_div_pkg.sv
// Shared constants, FSM state encoding and float field helpers for the
// Newton-Raphson divider sequencer.
package fp_div_pkg;

    // Initial-estimate coefficients: X0 = 48/17 - 32/17 * D'
    localparam logic [31:0] C1   = 32'h4034B4B5;
    localparam logic [31:0] C2   = 32'h3FF0F0F1;
    localparam logic [31:0] TWO  = 32'h40000000;
    localparam logic [31:0] QNAN = 32'h7FC00000;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_CAPT    = 4'd1,
        S_EST_MUL = 4'd2,
        S_EST_ADD = 4'd3,
        S_IT_MUL1 = 4'd4,
        S_IT_ADD  = 4'd5,
        S_IT_MUL2 = 4'd6,
        S_FIN_MUL = 4'd7,
        S_SCALE   = 4'd8,
        S_DONE    = 4'd9
    } state_t;

    // Outcome of operand classification
    typedef struct packed {
        logic        special;
        logic [31:0] result;
        logic        div0;
        logic        nan;
    } spec_res_t;

    function automatic logic [7:0] fp_exp(input logic [31:0] f);
        return f[30:23];
    endfunction

    function automatic logic [22:0] fp_man(input logic [31:0] f);
        return f[22:0];
    endfunction

    // Exponent 0 is treated as zero: denormals are flushed
    function automatic logic fp_is_zero(input logic [31:0] f);
        return fp_exp(f) == 8'h00;
    endfunction

    function automatic logic fp_is_inf(input logic [31:0] f);
        return (fp_exp(f) == 8'hFF) && (fp_man(f) == 23'h0);
    endfunction

    function automatic logic fp_is_nan(input logic [31:0] f);
        return (fp_exp(f) == 8'hFF) && (fp_man(f) != 23'h0);
    endfunction

endpackage

// File: rtl/fp_div_special.sv
// Operand classification and special-case result/flag encoding.
import fp_div_pkg::*;

module fp_div_special (
    input  logic [31:0] n,
    input  logic [31:0] d,
    output spec_res_t   res
);

    logic sgn;
    assign sgn = n[31] ^ d[31];

    // Priority: NaN-producing cases, then divide-by-zero, then inf/zero results
    always_comb begin
        res = '0;
        if (fp_is_nan(n) || fp_is_nan(d) ||
            (fp_is_zero(n) && fp_is_zero(d)) ||
            (fp_is_inf(n) && fp_is_inf(d))) begin
            res.special = 1'b1;
            res.result  = QNAN;
            res.nan     = 1'b1;
        end else if (fp_is_zero(d)) begin
            res.special = 1'b1;
            res.result  = {sgn, 8'hFF, 23'h0};
            res.div0    = 1'b1;
        end else if (fp_is_inf(n)) begin
            res.special = 1'b1;
            res.result  = {sgn, 8'hFF, 23'h0};
        end else if (fp_is_zero(n) || fp_is_inf(d)) begin
            res.special = 1'b1;
            res.result  = {sgn, 31'h0};
        end
    end

endmodule

// File: rtl/fp_div_sequencer.sv
// Newton-Raphson divider controller time-sharing one FP multiplier and one
// FP adder. Divisor is normalised to [0.5,1), reciprocal refined ITERS
// times, then |N|*X is rescaled by the divisor exponent.
import fp_div_pkg::*;

module fp_div_sequencer #(
    parameter int ITERS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] n_in,
    input  logic [31:0] d_in,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        div0,
    output logic        ovf,
    output logic        unf,
    output logic        nan,
    output logic        mul_req,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic        mul_ack,
    input  logic [31:0] mul_p,
    output logic        add_req,
    output logic        add_sub,
    output logic [31:0] add_a,
    output logic [31:0] add_b,
    input  logic        add_ack,
    input  logic [31:0] add_s
);

    state_t      state;
    logic [31:0] n_r, d_r;
    logic [31:0] x_r;           // current reciprocal estimate
    logic [31:0] t_r;           // scratch: t, t2, and final product p
    logic [2:0]  it_cnt;
    spec_res_t   spec;

    logic [31:0]       d_norm;
    logic              sgn;
    logic signed [9:0] k_s, e_s;

    fp_div_special u_special (
        .n   (n_r),
        .d   (d_r),
        .res (spec)
    );

    assign busy   = (state != S_IDLE);
    assign d_norm = {1'b0, 8'd126, fp_man(d_r)};
    assign sgn    = n_r[31] ^ d_r[31];
    assign k_s    = signed'({2'b00, fp_exp(d_r)}) - 10'sd126;
    assign e_s    = signed'({2'b00, fp_exp(t_r)}) - k_s;

    // Operand muxes: driven only from registered state so they stay stable
    // for the whole time a request is waiting on its ack
    always_comb begin
        mul_a   = '0;
        mul_b   = '0;
        add_a   = '0;
        add_b   = '0;
        add_sub = 1'b0;
        case (state)
            S_EST_MUL: begin mul_a = C2;  mul_b = d_norm; end
            S_EST_ADD: begin add_a = C1;  add_b = t_r; add_sub = 1'b1; end
            S_IT_MUL1: begin mul_a = x_r; mul_b = d_norm; end
            S_IT_ADD:  begin add_a = TWO; add_b = t_r; add_sub = 1'b1; end
            S_IT_MUL2: begin mul_a = x_r; mul_b = t_r; end
            S_FIN_MUL: begin mul_a = {1'b0, n_r[30:0]}; mul_b = x_r; end
            default: ;
        endcase
    end

    // Sequencer: each op holds its req until ack, captures on the ack cycle,
    // and raises the next op's req in the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            n_r     <= '0;
            d_r     <= '0;
            x_r     <= '0;
            t_r     <= '0;
            it_cnt  <= '0;
            result  <= '0;
            div0    <= 1'b0;
            ovf     <= 1'b0;
            unf     <= 1'b0;
            nan     <= 1'b0;
            done    <= 1'b0;
            mul_req <= 1'b0;
            add_req <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    n_r   <= n_in;
                    d_r   <= d_in;
                    div0  <= 1'b0;
                    ovf   <= 1'b0;
                    unf   <= 1'b0;
                    nan   <= 1'b0;
                    state <= S_CAPT;
                end
                S_CAPT: if (spec.special) begin
                    result <= spec.result;
                    div0   <= spec.div0;
                    nan    <= spec.nan;
                    done   <= 1'b1;
                    state  <= S_DONE;
                end else begin
                    mul_req <= 1'b1;
                    state   <= S_EST_MUL;
                end
                S_EST_MUL: if (mul_ack) begin
                    t_r     <= mul_p;
                    mul_req <= 1'b0;
                    add_req <= 1'b1;
                    state   <= S_EST_ADD;
                end
                S_EST_ADD: if (add_ack) begin
                    x_r     <= add_s;
                    add_req <= 1'b0;
                    mul_req <= 1'b1;
                    it_cnt  <= 3'(ITERS);
                    state   <= S_IT_MUL1;
                end
                S_IT_MUL1: if (mul_ack) begin
                    t_r     <= mul_p;
                    mul_req <= 1'b0;
                    add_req <= 1'b1;
                    state   <= S_IT_ADD;
                end
                S_IT_ADD: if (add_ack) begin
                    t_r     <= add_s;
                    add_req <= 1'b0;
                    mul_req <= 1'b1;
                    state   <= S_IT_MUL2;
                end
                S_IT_MUL2: if (mul_ack) begin
                    x_r    <= mul_p;
                    it_cnt <= it_cnt - 3'd1;
                    state  <= (it_cnt == 3'd1) ? S_FIN_MUL : S_IT_MUL1;
                end
                S_FIN_MUL: if (mul_ack) begin
                    t_r     <= mul_p;
                    mul_req <= 1'b0;
                    state   <= S_SCALE;
                end
                S_SCALE: begin
                    if (e_s >= 10'sd255) begin
                        result <= {sgn, 8'hFF, 23'h0};
                        ovf    <= 1'b1;
                    end else if (e_s <= 10'sd0) begin
                        result <= {sgn, 31'h0};
                        unf    <= 1'b1;
                    end else begin
                        result <= {sgn, e_s[7:0], fp_man(t_r)};
                    end
                    done  <= 1'b1;
                    state <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_div_sequencer.sv
// Directed bench for fp_div_sequencer with behavioural FP units that ack
// one cycle after a request rises (plus optional stall on the estimate mul).
module tb_fp_div_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] n_in = '0, d_in = '0;
    logic        busy, done, div0, ovf, unf, nan;
    logic [31:0] result;
    logic        mul_req, add_req, add_sub;
    logic [31:0] mul_a, mul_b, add_a, add_b;
    logic        mul_ack = 1'b0, add_ack = 1'b0;
    logic [31:0] mul_p = '0, add_s = '0;

    int tests = 0;
    int fails = 0;
    int mul_hs = 0, add_hs = 0, overlap = 0, stab_err = 0;
    int mul_stall = 0;
    int mul_cnt = 0, add_cnt = 0;
    logic [31:0] ma0, mb0;

    fp_div_sequencer #(.ITERS(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .n_in(n_in), .d_in(d_in),
        .busy(busy), .done(done), .result(result),
        .div0(div0), .ovf(ovf), .unf(unf), .nan(nan),
        .mul_req(mul_req), .mul_a(mul_a), .mul_b(mul_b), .mul_ack(mul_ack), .mul_p(mul_p),
        .add_req(add_req), .add_sub(add_sub), .add_a(add_a), .add_b(add_b),
        .add_ack(add_ack), .add_s(add_s)
    );

    always #5 clk = ~clk;

    function automatic real f2r(input logic [31:0] f);
        real m;
        int  e;
        if (f[30:23] == 8'd0) return 0.0;
        m = 1.0 + real'(f[22:0]) / 8388608.0;
        e = int'(f[30:23]) - 127;
        while (e > 0) begin m = m * 2.0; e--; end
        while (e < 0) begin m = m / 2.0; e++; end
        return f[31] ? -m : m;
    endfunction

    function automatic logic [31:0] r2f(input real r);
        real    a;
        int     e;
        longint mi;
        logic   s;
        if (r == 0.0) return 32'h0;
        s = (r < 0.0);
        a = s ? -r : r;
        e = 0;
        while (a >= 2.0) begin a = a / 2.0; e++; end
        while (a < 1.0)  begin a = a * 2.0; e--; end
        mi = longint'((a - 1.0) * 8388608.0);
        if (mi >= 8388608) begin mi = 0; e++; end
        e = e + 127;
        if (e >= 255) return {s, 8'hFF, 23'h0};
        if (e <= 0)   return {s, 31'h0};
        return {s, e[7:0], mi[22:0]};
    endfunction

    // Behavioural multiplier: ack in the cycle after req rises (+stall on C2*D')
    always @(negedge clk) begin
        if (!rst_n) begin
            mul_ack = 1'b0;
            mul_cnt = 0;
        end else if (mul_ack) begin
            mul_ack = 1'b0;
            mul_cnt = mul_req ? 1 : 0;
            ma0 = mul_a;
            mb0 = mul_b;
        end else if (mul_req) begin
            mul_cnt++;
            if (mul_cnt == 1) begin
                ma0 = mul_a;
                mb0 = mul_b;
            end else if (mul_a !== ma0 || mul_b !== mb0) begin
                stab_err++;
            end
            if (mul_cnt >= 2 + ((mul_a == 32'h3FF0F0F1) ? mul_stall : 0)) begin
                mul_p   = r2f(f2r(mul_a) * f2r(mul_b));
                mul_ack = 1'b1;
            end
        end
    end

    // Behavioural adder/subtractor
    always @(negedge clk) begin
        if (!rst_n) begin
            add_ack = 1'b0;
            add_cnt = 0;
        end else if (add_ack) begin
            add_ack = 1'b0;
            add_cnt = add_req ? 1 : 0;
        end else if (add_req) begin
            add_cnt++;
            if (add_cnt >= 2) begin
                add_s   = r2f(add_sub ? f2r(add_a) - f2r(add_b) : f2r(add_a) + f2r(add_b));
                add_ack = 1'b1;
            end
        end
    end

    // Handshake and exclusivity monitor
    always @(posedge clk) begin
        if (mul_req && mul_ack) mul_hs++;
        if (add_req && add_ack) add_hs++;
        if (mul_req && add_req) overlap++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic chk_ulp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        logic [31:0] diff;
        diff = (obs > exp) ? obs - exp : exp - obs;
        tests++;
        assert (diff <= 32'd1) else begin
            fails++;
            $error("FAIL %s: got %h want %h +-1ulp", tag, obs, exp);
        end
    endtask

    // Issue one divide; returns the cycle (accept = 0) in which done was seen.
    // ign_at: cycle to pulse a stray start. rst_at: cycle to pulse rst_n.
    task automatic run(input logic [31:0] n, input logic [31:0] d,
                       input int ign_at, input int rst_at,
                       output int cyc, output int muls, output int adds);
        int m0, a0;
        @(negedge clk);
        n_in  = n;
        d_in  = d;
        start = 1'b1;
        m0 = mul_hs;
        a0 = add_hs;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 0;
        while (1) begin
            @(negedge clk);
            cyc++;
            if (cyc == ign_at) begin
                start = 1'b1;
                n_in  = 32'h3F800000;
                d_in  = 32'h00000000;
            end else if (cyc == ign_at + 1) begin
                start = 1'b0;
            end
            if (cyc == rst_at) begin
                rst_n = 1'b0;
                #1;
                chk("rst_async", {28'h0, busy, mul_req, add_req, done}, 32'h0);
                @(negedge clk);
                @(negedge clk);
                rst_n = 1'b1;
                break;
            end
            if (done || cyc >= 300) break;
        end
        muls = mul_hs - m0;
        adds = add_hs - a0;
    endtask

    initial begin
        int cyc, muls, adds;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ctl", {26'h0, busy, done, mul_req, add_req, 2'b00}, 32'h0);
        chk("rst_result", result, 32'h0);
        chk("rst_flags", {28'h0, div0, ovf, unf, nan}, 32'h0);
        chk("rst_mul_a", mul_a, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // 6 / 3
        run(32'h40C00000, 32'h40400000, 0, 0, cyc, muls, adds);
        chk("6/3 cycle", cyc, 33);
        chk_ulp("6/3 result", result, 32'h40000000);
        chk("6/3 muls", muls, 10);
        chk("6/3 adds", adds, 5);
        chk("6/3 flags", {28'h0, div0, ovf, unf, nan}, 32'h0);

        // -7.5 / 2.5
        run(32'hC0F00000, 32'h40200000, 0, 0, cyc, muls, adds);
        chk("neg cycle", cyc, 33);
        chk_ulp("neg result", result, 32'hC0400000);
        chk("neg flags", {28'h0, div0, ovf, unf, nan}, 32'h0);

        // 1 / 0
        run(32'h3F800000, 32'h00000000, 0, 0, cyc, muls, adds);
        chk("1/0 cycle", cyc, 2);
        chk("1/0 result", result, 32'h7F800000);
        chk("1/0 flags", {28'h0, div0, ovf, unf, nan}, 32'h8);
        chk("1/0 reqs", muls + adds, 0);

        // 0 / 0
        run(32'h00000000, 32'h00000000, 0, 0, cyc, muls, adds);
        chk("0/0 cycle", cyc, 2);
        chk("0/0 result", result, 32'h7FC00000);
        chk("0/0 flags", {28'h0, div0, ovf, unf, nan}, 32'h1);
        chk("0/0 reqs", muls + adds, 0);

        // 5 / inf
        run(32'h40A00000, 32'h7F800000, 0, 0, cyc, muls, adds);
        chk("5/inf cycle", cyc, 2);
        chk("5/inf result", result, 32'h00000000);
        chk("5/inf flags", {28'h0, div0, ovf, unf, nan}, 32'h0);
        chk("5/inf reqs", muls + adds, 0);

        // Overflow
        run(32'h7F000000, 32'h00800000, 0, 0, cyc, muls, adds);
        chk("ovf result", result, 32'h7F800000);
        chk("ovf flags", {28'h0, div0, ovf, unf, nan}, 32'h4);

        // Underflow
        run(32'h00800000, 32'h7F000000, 0, 0, cyc, muls, adds);
        chk("unf result", result, 32'h00000000);
        chk("unf flags", {28'h0, div0, ovf, unf, nan}, 32'h2);

        // Stall the estimate multiply by 5 cycles
        mul_stall = 5;
        stab_err  = 0;
        run(32'h40C00000, 32'h40400000, 0, 0, cyc, muls, adds);
        mul_stall = 0;
        chk("stall cycle", cyc, 38);
        chk_ulp("stall result", result, 32'h40000000);
        chk("stall stable", stab_err, 0);
        chk("stall muls", muls, 10);

        // Async reset mid-operation, then a clean run with a stray start
        run(32'h40C00000, 32'h40400000, 0, 12, cyc, muls, adds);
        chk("rst result", result, 32'h0);
        chk("rst busy", {31'h0, busy}, 32'h0);
        @(negedge clk);
        run(32'h40C00000, 32'h40400000, 10, 0, cyc, muls, adds);
        chk("fresh cycle", cyc, 33);
        chk_ulp("fresh result", result, 32'h40000000);
        chk("fresh flags", {28'h0, div0, ovf, unf, nan}, 32'h0);
        chk("fresh muls", muls, 10);
        chk("fresh adds", adds, 5);

        chk("req overlap", overlap, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
